// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch resolution, predictor update, flush and fetch redirect
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [XLEN-1:0]              pred_pc,
    input  logic [XLEN-1:0]              pred_target,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic [XLEN-1:0]              res_target,
    output logic                         branch_ins,
    output logic                         PredictFailed,
    output logic                         flush,
    output logic                         redirect_valid,
    output logic [XLEN-1:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]       inflight,
    output logic                         err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              alive_q;
    logic              err_q, err_d;
    logic              bi_q, bi_d, pf_q, pf_d, rv_q, rv_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;

    logic              mem_taken [DEPTH];
    logic [XLEN-1:0]   mem_pc    [DEPTH];
    logic [XLEN-1:0]   mem_tgt   [DEPTH];

    logic              empty, full, push, mispredict;
    logic              head_taken;
    logic [XLEN-1:0]   head_pc, head_tgt;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // alive_q keeps ready low until the first clock after reset release
    assign pred_ready = alive_q && !full && (state_q == S_IDLE);
    assign push       = pred_valid && pred_ready;

    assign head_taken = mem_taken[rd_ptr_q[AW-1:0]];
    assign head_pc    = mem_pc[rd_ptr_q[AW-1:0]];
    assign head_tgt   = mem_tgt[rd_ptr_q[AW-1:0]];
    assign mispredict = (res_taken != head_taken) | (res_taken & (head_tgt != res_target));

    assign branch_ins     = bi_q;
    assign PredictFailed  = pf_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign flush          = (state_q == S_FLUSH);
    assign inflight       = wr_ptr_q - rd_ptr_q;
    assign err_underflow  = err_q;

    // Entry storage; a push discarded by a mispredict clear lands in a slot that is never read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_taken[wr_ptr_q[AW-1:0]] <= pred_taken;
            mem_pc[wr_ptr_q[AW-1:0]]    <= pred_pc;
            mem_tgt[wr_ptr_q[AW-1:0]]   <= pred_target;
        end
    end

    // Next-state: queue bookkeeping, resolve compare and flush countdown
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        bi_d     = 1'b0;
        pf_d     = 1'b0;
        rv_d     = 1'b0;
        rpc_d    = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (res_valid && empty) begin
                    err_d = 1'b1;
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (res_valid && !empty) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    bi_d     = 1'b1;
                    pf_d     = mispredict;
                    if (mispredict) begin
                        rv_d     = 1'b1;
                        rpc_d    = res_taken ? res_target : head_pc + XLEN'(4);
                        state_d  = S_FLUSH;
                        cnt_d    = CNT_LOAD;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            alive_q  <= 1'b0;
            err_q    <= 1'b0;
            bi_q     <= 1'b0;
            pf_q     <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            alive_q  <= 1'b1;
            err_q    <= err_d;
            bi_q     <= bi_d;
            pf_q     <= pf_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
        end
    end
endmodule
